cache_repl_policy: RTL and testbench

// Per-set cache victim selector; successor to the fixed-random replacer, with run-time selectable policy.
// - Policies: tree pseudo-LRU, LFSR random, per-set round-robin.
// - Keeps a state entry for every set and always prefers an invalid way.
// - Sits beside the tag/data arrays in the I$/D$ cache controller; feeds VictimWay to the way muxes and write enables.

---
 rtl/cache_repl_pkg.sv | 51 +++++
 rtl/repl_lfsr.sv | 20 ++
 rtl/cache_repl_policy.sv | 122 ++++++++++++
 tb/tb_cache_repl_policy.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_repl_pkg.sv
// Shared types and tree-PLRU helpers for the cache victim selector.
// Tree functions work on a fixed-width heap; callers size-cast to their own tree width.
package cache_repl_pkg;

  typedef enum logic [1:0] {
    REPL_PLRU = 2'b00,
    REPL_RAND = 2'b01,
    REPL_RR   = 2'b10,
    REPL_RSVD = 2'b11
  } repl_policy_t;

  localparam int unsigned PLRU_MAXWAYS = 64;
  localparam int unsigned PLRU_MAXLG   = 6;

  typedef logic [PLRU_MAXWAYS-2:0] plru_tree_t;

  // Walk from the root following each node's pointer; the leaf reached is the victim.
  function automatic int unsigned plru_victim(input plru_tree_t tree, input int unsigned lg);
    int unsigned node;
    logic [PLRU_MAXLG-1:0] idx;
    node = 1;
    for (int unsigned i = 0; i < PLRU_MAXLG; i++) begin
      if (i < lg) begin
        idx  = PLRU_MAXLG'(node - 1);
        node = (node << 1) + {31'b0, tree[idx]};
      end
    end
    return node - (32'd1 << lg);
  endfunction

  // Point every node on the accessed way's path at the opposite subtree.
  function automatic plru_tree_t plru_update(input plru_tree_t tree, input int unsigned way,
                                             input int unsigned lg);
    plru_tree_t    t;
    int unsigned   node;
    int unsigned   dir;
    logic [PLRU_MAXLG-1:0] idx;
    t    = tree;
    node = 1;
    for (int unsigned i = 0; i < PLRU_MAXLG; i++) begin
      if (i < lg) begin
        dir    = (way >> (lg - 1 - i)) & 32'd1;
        idx    = PLRU_MAXLG'(node - 1);
        t[idx] = (dir == 0);
        node   = (node << 1) + dir;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/repl_lfsr.sv
// Galois right-shift LFSR used as the random replacement source.
module repl_lfsr #(
  parameter int unsigned         LFSRLEN  = 16,
  parameter logic [LFSRLEN-1:0]  LFSRTAPS = 16'hB400,
  parameter logic [LFSRLEN-1:0]  LFSRSEED = 16'h0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Advance,
  output logic [LFSRLEN-1:0] Value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Value <= LFSRSEED;
    else if (Advance)
      Value <= (Value >> 1) ^ (Value[0] ? LFSRTAPS : '0);
  end

endmodule

// File: rtl/cache_repl_policy.sv
// Per-set victim selector: tree PLRU, LFSR random or round-robin, invalid ways first.
// Per-set state lives in a flop array; the read set is registered into curr with write bypass.
module cache_repl_policy
  import cache_repl_pkg::*;
#(
  parameter int unsigned         NUMWAYS  = 4,
  parameter int unsigned         SETLEN   = 9,
  parameter int unsigned         NUMLINES = 128,
  parameter int unsigned         LFSRLEN  = 16,
  parameter logic [LFSRLEN-1:0]  LFSRTAPS = 16'hB400,
  parameter logic [LFSRLEN-1:0]  LFSRSEED = 16'h0001
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       FlushStage,
  input  logic                       CacheEn,
  input  logic [1:0]                 PolicySel,
  input  logic [NUMWAYS-1:0]         HitWay,
  input  logic [NUMWAYS-1:0]         ValidWay,
  input  logic [SETLEN-1:0]          CacheSetData,
  input  logic [SETLEN-1:0]          CacheSetTag,
  input  logic                       LRUWriteEn,
  input  logic                       SetValid,
  input  logic                       InvalidateCache,
  output logic [NUMWAYS-1:0]         VictimWay,
  output logic [$clog2(NUMWAYS)-1:0] VictimWayEnc
);

  localparam int unsigned LG   = $clog2(NUMWAYS);
  localparam int unsigned IDXW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;

  if (LFSRLEN < LG || LFSRSEED == '0) begin : g_bad_lfsr
    $error("cache_repl_policy: LFSRLEN must be >= log2(NUMWAYS) and LFSRSEED nonzero");
  end
  if (NUMWAYS < 2 || NUMWAYS > PLRU_MAXWAYS || (1 << LG) != NUMWAYS) begin : g_bad_ways
    $error("cache_repl_policy: NUMWAYS must be a power of 2 in [2, 64]");
  end

  typedef struct packed {
    logic [NUMWAYS-2:0] plru;
    logic [LG-1:0]      rr;
  } set_state_t;

  set_state_t         state [NUMLINES];
  set_state_t         curr;
  set_state_t         next_state;
  logic [IDXW-1:0]    rd_idx;
  logic [IDXW-1:0]    wr_idx;
  logic               upd;
  logic [LFSRLEN-1:0] lfsr_val;
  logic [LG-1:0]      rand_enc;
  logic [LG-1:0]      inv_enc;
  logic               inv_found;
  logic [LG-1:0]      hit_enc;
  logic [LG-1:0]      pol_enc;
  logic [LG-1:0]      victim_enc;
  logic [LG-1:0]      way;

  assign rd_idx   = IDXW'(CacheSetData);
  assign wr_idx   = IDXW'(CacheSetTag);
  assign upd      = LRUWriteEn & ~FlushStage & ~InvalidateCache;
  assign rand_enc = LG'(lfsr_val);

  repl_lfsr #(
    .LFSRLEN  (LFSRLEN),
    .LFSRTAPS (LFSRTAPS),
    .LFSRSEED (LFSRSEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .Advance (upd & SetValid),
    .Value   (lfsr_val)
  );

  always_comb begin
    inv_found = 1'b0;
    inv_enc   = '0;
    hit_enc   = '0;
    for (int unsigned w = 0; w < NUMWAYS; w++) begin
      if (!ValidWay[w] && !inv_found) begin
        inv_found = 1'b1;
        inv_enc   = LG'(w);
      end
      if (HitWay[w])
        hit_enc = hit_enc | LG'(w);
    end

    case (repl_policy_t'(PolicySel))
      REPL_RAND: pol_enc = rand_enc;
      REPL_RR:   pol_enc = curr.rr;
      default:   pol_enc = LG'(plru_victim(plru_tree_t'(curr.plru), LG));
    endcase

    victim_enc = inv_found ? inv_enc : pol_enc;
    VictimWay  = '0;
    VictimWay[victim_enc] = 1'b1;
    VictimWayEnc = victim_enc;

    way             = SetValid ? victim_enc : hit_enc;
    next_state.plru = (NUMWAYS-1)'(plru_update(plru_tree_t'(curr.plru), 32'(way), LG));
    next_state.rr   = SetValid ? curr.rr + LG'(1) : curr.rr;
  end

  // A write to the set being read on the same edge is forwarded into curr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUMLINES; i++)
        state[i] <= '0;
      curr <= '0;
    end else if (InvalidateCache) begin
      for (int unsigned i = 0; i < NUMLINES; i++)
        state[i] <= '0;
      curr <= '0;
    end else begin
      if (upd)
        state[wr_idx] <= next_state;
      if (CacheEn)
        curr <= (upd && wr_idx == rd_idx) ? next_state : state[rd_idx];
    end
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed-vector bench for cache_repl_policy (4 ways, default LFSR).
module tb_cache_repl_policy;
  import cache_repl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       FlushStage;
  logic       CacheEn;
  logic [1:0] PolicySel;
  logic [3:0] HitWay;
  logic [3:0] ValidWay;
  logic [8:0] CacheSetData;
  logic [8:0] CacheSetTag;
  logic       LRUWriteEn;
  logic       SetValid;
  logic       InvalidateCache;
  logic [3:0] VictimWay;
  logic [1:0] VictimWayEnc;

  int n_cmp = 0;
  int n_err = 0;

  cache_repl_policy #(
    .NUMWAYS  (4),
    .SETLEN   (9),
    .NUMLINES (128),
    .LFSRLEN  (16),
    .LFSRTAPS (16'hB400),
    .LFSRSEED (16'h0001)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .FlushStage      (FlushStage),
    .CacheEn         (CacheEn),
    .PolicySel       (PolicySel),
    .HitWay          (HitWay),
    .ValidWay        (ValidWay),
    .CacheSetData    (CacheSetData),
    .CacheSetTag     (CacheSetTag),
    .LRUWriteEn      (LRUWriteEn),
    .SetValid        (SetValid),
    .InvalidateCache (InvalidateCache),
    .VictimWay       (VictimWay),
    .VictimWayEnc    (VictimWayEnc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    LRUWriteEn      = 1'b0;
    SetValid        = 1'b0;
    HitWay          = '0;
    FlushStage      = 1'b0;
    InvalidateCache = 1'b0;
    CacheEn         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int s);
    CacheEn      = 1'b1;
    CacheSetData = 9'(s);
    tick();
    CacheEn = 1'b0;
  endtask

  // Update set s (hit on way w, or fill when f) while re-reading the same set.
  task automatic acc(input int s, input int w, input bit f);
    CacheEn      = 1'b1;
    CacheSetData = 9'(s);
    CacheSetTag  = 9'(s);
    LRUWriteEn   = 1'b1;
    SetValid     = f;
    HitWay       = f ? 4'b0000 : 4'(4'b0001 << w);
    tick();
    clr();
  endtask

  // Random victims for LFSR states 1, B400, 5A00, ... , 9905, F882
  logic [1:0] rand_exp [16] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

  initial begin
    clr();
    reset        = 1'b1;
    PolicySel    = REPL_PLRU;
    ValidWay     = 4'b0000;
    CacheSetData = '0;
    CacheSetTag  = '0;
    #12;
    reset = 1'b0;
    tick();

    chk("rst_inv_none", 32'(VictimWay), 32'h1);
    chk("rst_inv_none_enc", 32'(VictimWayEnc), 32'h0);
    ValidWay = 4'b1011;
    #1;
    chk("rst_inv_way2", 32'(VictimWay), 32'h4);
    ValidWay = 4'b1111;
    #1;
    chk("rst_plru", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RR;
    #1;
    chk("rst_rr", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RAND;
    #1;
    chk("rst_rand", 32'(VictimWayEnc), 32'h1);

    rd(0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rand_%0d", k), 32'(VictimWayEnc), 32'(rand_exp[k]));
      if (k == 3) begin
        acc(0, 1, 1'b0);
        chk("rand_hit_no_adv", 32'(VictimWayEnc), 32'(rand_exp[3]));
      end
      if (k < 15)
        acc(0, 0, 1'b1);
    end

    PolicySel = REPL_PLRU;
    rd(5);
    chk("plru_init", 32'(VictimWayEnc), 32'h0);
    acc(5, 0, 1'b0);
    rd(5);
    chk("plru_hit0", 32'(VictimWayEnc), 32'h2);
    acc(5, 2, 1'b0);
    rd(5);
    chk("plru_hit2", 32'(VictimWayEnc), 32'h1);
    chk("plru_hit2_oh", 32'(VictimWay), 32'h2);
    FlushStage = 1'b1;
    acc(5, 1, 1'b0);
    rd(5);
    chk("plru_flush", 32'(VictimWayEnc), 32'h1);
    rd(6);
    chk("plru_other_set", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RSVD;
    #1;
    chk("rsvd_as_plru", 32'(VictimWayEnc), 32'h0);

    PolicySel = REPL_RR;
    rd(3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_fill_%0d", k), 32'(VictimWayEnc), 32'(k % 4));
      acc(3, 0, 1'b1);
      acc(3, 2, 1'b0);
    end

    PolicySel = REPL_PLRU;
    rd(7);
    chk("byp_before", 32'(VictimWayEnc), 32'h0);
    acc(7, 0, 1'b0);
    chk("byp_same_edge", 32'(VictimWayEnc), 32'h2);

    InvalidateCache = 1'b1;
    acc(7, 3, 1'b0);
    chk("inval_curr", 32'(VictimWayEnc), 32'h0);
    rd(5);
    chk("inval_set5", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RR;
    rd(3);
    chk("inval_rr_set3", 32'(VictimWayEnc), 32'h0);

    PolicySel = REPL_PLRU;
    rd(5);
    acc(5, 0, 1'b0);
    chk("pre_reset_set5", 32'(VictimWayEnc), 32'h2);
    CacheEn      = 1'b1;
    CacheSetData = 9'd5;
    CacheSetTag  = 9'd5;
    LRUWriteEn   = 1'b1;
    SetValid     = 1'b1;
    #3;
    reset = 1'b1;
    #10;
    reset = 1'b0;
    clr();
    #1;
    chk("midrst_curr", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RAND;
    #1;
    chk("midrst_lfsr_seed", 32'(VictimWayEnc), 32'h1);
    PolicySel = REPL_PLRU;
    rd(5);
    chk("midrst_set5", 32'(VictimWayEnc), 32'h0);

    PolicySel = REPL_RR;
    rd(9);
    acc(9, 0, 1'b1);
    acc(9, 0, 1'b1);
    PolicySel = REPL_PLRU;
    #1;
    chk("switch_plru", 32'(VictimWayEnc), 32'h2);
    acc(9, 2, 1'b0);
    chk("switch_plru_hit", 32'(VictimWayEnc), 32'h0);
    PolicySel = REPL_RR;
    #1;
    chk("switch_back_rr", 32'(VictimWayEnc), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
